// File: rtl/alu_op_sequencer.sv
// Issue controller for the ALU result mux: accepts one op per handshake, times
// single- and multi-cycle units, and buffers the selected result with backpressure.
module alu_op_sequencer #(
    parameter int unsigned N       = 4,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DIV_LAT = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         op_valid,
    input  logic [3:0]   op_code,
    output logic         op_ready,
    input  logic         abort,
    output logic [3:0]   alu_select,
    output logic         mc_start,
    input  logic [N-1:0] alu_result,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic         res_zero,
    output logic         res_err,
    output logic         busy
);

    localparam int unsigned LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CW      = $clog2(LAT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] op_lat;
    logic          accept;
    logic          illegal;
    logic          is_mc;
    logic          last_cycle;

    always_comb begin
        op_ready   = ((state == IDLE) || ((state == DONE) && res_ready)) && !abort;
        accept     = op_valid && op_ready;
        illegal    = (op_code > 4'd11);
        is_mc      = (op_code == 4'd2) || (op_code == 4'd5) || (op_code == 4'd11);
        last_cycle = (state == EXEC) && (cnt == CW'(1));
        res_valid  = (state == DONE);
        busy       = (state != IDLE);

        case (op_code)
            4'd2:        op_lat = CW'(MUL_LAT);
            4'd5, 4'd11: op_lat = CW'(DIV_LAT);
            default:     op_lat = CW'(1);
        endcase

        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state_nxt = illegal ? DONE : EXEC;
                EXEC: if (last_cycle) state_nxt = DONE;
                DONE: begin
                    // accept in DONE implies res_ready: drain and reissue with no bubble
                    if (accept)         state_nxt = illegal ? DONE : EXEC;
                    else if (res_ready) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            alu_select <= '0;
            mc_start   <= 1'b0;
            res_data   <= '0;
            res_zero   <= 1'b0;
            res_err    <= 1'b0;
        end else begin
            state    <= state_nxt;
            mc_start <= 1'b0;
            if (abort) begin
                cnt <= '0;
            end else if (accept) begin
                alu_select <= op_code;
                if (illegal) begin
                    cnt      <= '0;
                    res_data <= '0;
                    res_zero <= 1'b1;
                    res_err  <= 1'b1;
                end else begin
                    cnt      <= op_lat;
                    mc_start <= is_mc;
                end
            end else if (state == EXEC) begin
                cnt <= cnt - CW'(1);
                if (last_cycle) begin
                    res_data <= alu_result;
                    res_zero <= (alu_result == '0);
                    res_err  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised op stream against a transaction-level model of the sequencer's
// latency, select, start-pulse and result-buffer rules, plus abort/reset cases.
module tb_alu_op_sequencer;

    localparam int unsigned N       = 4;
    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned DIV_LAT = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         op_valid;
    logic [3:0]   op_code;
    logic         op_ready;
    logic         abort;
    logic [3:0]   alu_select;
    logic         mc_start;
    logic [N-1:0] alu_result;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_data;
    logic         res_zero;
    logic         res_err;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    alu_op_sequencer #(.N(N), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
        .op_ready(op_ready), .abort(abort), .alu_select(alu_select),
        .mc_start(mc_start), .alu_result(alu_result), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_zero(res_zero),
        .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned lat_of(input logic [3:0] code);
        if (code == 4'd2) return MUL_LAT;
        if (code == 4'd5 || code == 4'd11) return DIV_LAT;
        return 1;
    endfunction

    function automatic logic uses_mc(input logic [3:0] code);
        return (code == 4'd2) || (code == 4'd5) || (code == 4'd11);
    endfunction

    // Entered just after a negedge with the DUT in IDLE or DONE; returns in DONE.
    task automatic do_op(input logic [3:0] code, input int unsigned hold, input int force_res);
        int unsigned  lat;
        logic [N-1:0] exp_d;
        logic         exp_z;
        logic         exp_e;
        lat = lat_of(code);
        exp_d = '0;
        op_valid = 1'b1; op_code = code; res_ready = 1'b1; alu_result = N'($urandom);
        #1 chk("accept_rdy", {7'd0, op_ready}, 8'd1);
        @(negedge clk);
        op_valid = 1'b0; res_ready = 1'b0; op_code = 4'($urandom);
        if (code > 4'd11) begin
            exp_d = '0; exp_z = 1'b1; exp_e = 1'b1;
        end else begin
            for (int unsigned k = 1; k <= lat; k++) begin
                chk("exec_valid", {7'd0, res_valid}, 8'd0);
                chk("exec_busy", {7'd0, busy}, 8'd1);
                chk("exec_sel", {4'd0, alu_select}, {4'd0, code});
                chk("mc_start", {7'd0, mc_start}, {7'd0, (k == 1) && uses_mc(code)});
                alu_result = (force_res >= 0 && k == lat) ? N'(force_res) : N'($urandom);
                if (k == lat) exp_d = alu_result;
                #1 chk("exec_rdy", {7'd0, op_ready}, 8'd0);
                @(negedge clk);
            end
            exp_z = (exp_d == '0); exp_e = 1'b0;
        end
        chk("done_valid", {7'd0, res_valid}, 8'd1);
        chk("done_data", {4'd0, res_data}, {4'd0, exp_d});
        chk("done_zero", {7'd0, res_zero}, {7'd0, exp_z});
        chk("done_err", {7'd0, res_err}, {7'd0, exp_e});
        chk("done_sel", {4'd0, alu_select}, {4'd0, code});
        chk("done_mc", {7'd0, mc_start}, 8'd0);
        for (int unsigned h = 0; h < hold; h++) begin
            alu_result = N'($urandom);
            #1 chk("hold_rdy", {7'd0, op_ready}, 8'd0);
            @(negedge clk);
            chk("hold_valid", {7'd0, res_valid}, 8'd1);
            chk("hold_data", {4'd0, res_data}, {4'd0, exp_d});
            chk("hold_err", {7'd0, res_err}, {7'd0, exp_e});
        end
    endtask

    task automatic drain();
        res_ready = 1'b1;
        #1 chk("drain_rdy", {7'd0, op_ready}, 8'd1);
        @(negedge clk);
        res_ready = 1'b0;
        chk("drain_valid", {7'd0, res_valid}, 8'd0);
        chk("drain_busy", {7'd0, busy}, 8'd0);
        #1 chk("idle_rdy", {7'd0, op_ready}, 8'd1);
    endtask

    task automatic quiet(input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) begin
            alu_result = N'($urandom);
            @(negedge clk);
            chk("quiet_valid", {7'd0, res_valid}, 8'd0);
            chk("quiet_busy", {7'd0, busy}, 8'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; op_code = '0; abort = 1'b0;
        alu_result = '0; res_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_rdy", {7'd0, op_ready}, 8'd1);
        chk("rst_valid", {7'd0, res_valid}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_sel", {4'd0, alu_select}, 8'd0);
        chk("rst_mc", {7'd0, mc_start}, 8'd0);
        chk("rst_data", {4'd0, res_data}, 8'd0);
        chk("rst_flags", {6'd0, res_zero, res_err}, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed sequence from the block's reference scenarios
        do_op(4'd1, 0, 5);
        drain();
        do_op(4'd2, 0, 12);
        drain();
        do_op(4'd13, 0, -1);
        drain();
        do_op(4'd7, 5, 0);
        do_op(4'd6, 0, -1);
        drain();

        for (int i = 0; i < 40; i++) begin
            do_op(4'($urandom_range(0, 15)), $urandom_range(0, 3), -1);
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();

        // abort during div EXEC
        op_valid = 1'b1; op_code = 4'd5;
        #1 chk("abort_acc_rdy", {7'd0, op_ready}, 8'd1);
        @(negedge clk);
        op_valid = 1'b0;
        chk("abort_mc", {7'd0, mc_start}, 8'd1);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        #1 chk("abort_rdy", {7'd0, op_ready}, 8'd0);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", {7'd0, busy}, 8'd0);
        chk("abort_valid", {7'd0, res_valid}, 8'd0);
        #1 chk("abort_post_rdy", {7'd0, op_ready}, 8'd1);
        quiet(10);

        // abort wins over capture on a single-cycle op
        op_valid = 1'b1; op_code = 4'd9;
        @(negedge clk);
        op_valid = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        quiet(3);

        // abort wins over accept in DONE
        do_op(4'd1, 0, 3);
        op_valid = 1'b1; op_code = 4'd2; res_ready = 1'b1; abort = 1'b1;
        #1 chk("abort_done_rdy", {7'd0, op_ready}, 8'd0);
        @(negedge clk);
        op_valid = 1'b0; res_ready = 1'b0; abort = 1'b0;
        chk("abort_done_busy", {7'd0, busy}, 8'd0);
        chk("abort_done_mc", {7'd0, mc_start}, 8'd0);
        chk("abort_done_sel", {4'd0, alu_select}, 8'd1);
        quiet(3);

        // async reset during mod EXEC, after a nonzero result was buffered
        do_op(4'd3, 0, 9);
        op_valid = 1'b1; op_code = 4'd11; res_ready = 1'b1;
        @(negedge clk);
        op_valid = 1'b0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {7'd0, res_valid}, 8'd0);
        chk("arst_busy", {7'd0, busy}, 8'd0);
        chk("arst_sel", {4'd0, alu_select}, 8'd0);
        chk("arst_data", {4'd0, res_data}, 8'd0);
        chk("arst_mc", {7'd0, mc_start}, 8'd0);
        chk("arst_rdy", {7'd0, op_ready}, 8'd1);
        @(negedge clk);
        rst_n = 1'b1;
        quiet(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
